// File: rtl/io_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : io_mmio_controller
// Brief    : CPU memory-mapped I/O window for the key FIFO, number buffer,
//            LED register and VGA result register.
// Revision : 1.0 - initial release
// ============================================================================
module io_mmio_controller #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic        io_hit,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic [7:0]  ps2_scancode,
  input  logic        ps2_key_pressed,
  input  logic [31:0] num_buffer_in,
  input  logic        num_valid_in,
  output logic        num_read_ack,
  output logic [15:0] led_out,
  output logic [1:0]  vga_result_out
);

  localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_SCANCODE = 3'd1;
  localparam logic [2:0] OFF_NUMBER   = 3'd2;
  localparam logic [2:0] OFF_LED      = 3'd3;
  localparam logic [2:0] OFF_VGA      = 3'd4;
  localparam logic [2:0] OFF_CONTROL  = 3'd5;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             key_q;
  logic [31:0]      rdata_q;
  logic             rvalid_q;
  logic             ack_q;
  logic [15:0]      led_q;
  logic [1:0]       vga_q;

  logic [2:0]  off;
  logic        wr_hit, rd_hit, key_edge, empty, full, pop, push;
  logic [31:0] status, rd_mux;
  logic        unused_bits;

  assign io_hit      = (cpu_addr[31:5] == BASE_ADDR[31:5]);
  assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:16]};

  always_comb begin
    off      = cpu_addr[4:2];
    wr_hit   = io_hit && cpu_we;
    // A simultaneous store wins; the load is dropped without side effects.
    rd_hit   = io_hit && cpu_re && !cpu_we;
    key_edge = ps2_key_pressed && !key_q;
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    pop      = rd_hit && (off == OFF_SCANCODE) && !empty;
    push     = key_edge && (!full || pop);

    status              = '0;
    status[0]           = !empty;
    status[1]           = num_valid_in;
    status[2]           = ovf_q;
    status[3 +: CNT_W]  = count_q;

    rd_mux = '0;
    case (off)
      OFF_STATUS:   rd_mux = status;
      OFF_SCANCODE: rd_mux = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
      OFF_NUMBER:   rd_mux = num_buffer_in;
      OFF_LED:      rd_mux = {16'd0, led_q};
      OFF_VGA:      rd_mux = {30'd0, vga_q};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ps2_scancode;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      key_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      led_q    <= '0;
      vga_q    <= '0;
    end else begin
      key_q <= ps2_key_pressed;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

      // Set takes priority over a same-cycle clear.
      if (key_edge && full && !pop)
        ovf_q <= 1'b1;
      else if (wr_hit && (off == OFF_CONTROL) && cpu_wdata[0])
        ovf_q <= 1'b0;

      rvalid_q <= rd_hit;
      if (rd_hit) rdata_q <= rd_mux;
      ack_q <= rd_hit && (off == OFF_NUMBER) && num_valid_in;

      if (wr_hit && (off == OFF_LED)) led_q <= cpu_wdata[15:0];
      if (wr_hit && (off == OFF_VGA)) vga_q <= cpu_wdata[1:0];
    end
  end

  assign cpu_rdata      = rdata_q;
  assign cpu_rvalid     = rvalid_q;
  assign num_read_ack   = ack_q;
  assign led_out        = led_q;
  assign vga_result_out = vga_q;

endmodule
`default_nettype wire

// File: tb/tb_io_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_mmio_controller
// Brief    : Vector-table bench for io_mmio_controller plus corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_mmio_controller;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we, cpu_re;
  logic        io_hit;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [7:0]  ps2_scancode;
  logic        ps2_key_pressed;
  logic [31:0] num_buffer_in;
  logic        num_valid_in;
  logic        num_read_ack;
  logic [15:0] led_out;
  logic [1:0]  vga_result_out;

  int checks = 0;
  int errors = 0;

  io_mmio_controller #(.BASE_ADDR(B), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .io_hit(io_hit), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ps2_scancode(ps2_scancode), .ps2_key_pressed(ps2_key_pressed),
    .num_buffer_in(num_buffer_in), .num_valid_in(num_valid_in),
    .num_read_ack(num_read_ack), .led_out(led_out), .vga_result_out(vga_result_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;      // 0 key event, 1 read, 2 write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  code;
    logic [31:0] num;
    logic        nvalid;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] s_rdata;
  logic        s_rvalid, s_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic key_event(input logic [7:0] code);
    @(negedge clk);
    ps2_scancode = code; ps2_key_pressed = 1'b1;
    @(negedge clk);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic access(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    s_rdata = cpu_rdata; s_rvalid = cpu_rvalid; s_ack = num_read_ack;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    access(1'b0, 1'b1, addr, 32'd0);
    check({name, ".rvalid"}, {31'd0, s_rvalid}, 32'd1);
    check({name, ".rdata"}, s_rdata, exp);
  endtask

  function automatic vec_t mk(int k, logic [31:0] a, logic [31:0] w, logic [7:0] c,
                              logic [31:0] n, logic nv, logic [31:0] er, logic ev, logic ea);
    vec_t v;
    v.kind = k; v.addr = a; v.wdata = w; v.code = c; v.num = n; v.nvalid = nv;
    v.exp_rdata = er; v.exp_rvalid = ev; v.exp_ack = ea;
    return v;
  endfunction

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    ps2_scancode = 8'h99; ps2_key_pressed = 1'b0; num_buffer_in = '0; num_valid_in = 1'b0;

    // Reset held two cycles while the key line toggles.
    @(negedge clk); ps2_key_pressed = 1'b1;
    @(negedge clk); ps2_key_pressed = 1'b0;
    check("reset.rdata", cpu_rdata, 32'd0);
    check("reset.rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("reset.ack", {31'd0, num_read_ack}, 32'd0);
    check("reset.led", {16'd0, led_out}, 32'd0);
    check("reset.vga", {30'd0, vga_result_out}, 32'd0);
    rst = 1'b1;
    rd_check("reset.status", B, 32'd0);

    vecs.push_back(mk(0, 0, 0, 8'h16, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h1E, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h26, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 1,  0, 0, 0, 0, 32'h19, 1, 0));
    vecs.push_back(mk(1, B + 4,  0, 0, 0, 0, 32'h16, 1, 0));
    vecs.push_back(mk(1, B + 4,  0, 0, 0, 0, 32'h1E, 1, 0));
    vecs.push_back(mk(1, B + 4,  0, 0, 0, 0, 32'h26, 1, 0));
    vecs.push_back(mk(1, B + 4,  0, 0, 0, 0, 32'h00, 1, 0));
    vecs.push_back(mk(1, B,      0, 0, 0, 0, 32'h00, 1, 0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 8'(i), 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B,      0, 0, 0, 0, 32'h25, 1, 0));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, B + 4, 0, 0, 0, 0, 32'(i), 1, 0));
    vecs.push_back(mk(1, B,      0, 0, 0, 0, 32'h04, 1, 0));
    vecs.push_back(mk(2, B + 20, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B,      0, 0, 0, 0, 32'h00, 1, 0));
    vecs.push_back(mk(1, B,      0, 0, 0, 1, 32'h02, 1, 0));
    vecs.push_back(mk(1, B + 8,  0, 0, 1234, 1, 32'd1234, 1, 1));
    vecs.push_back(mk(1, B + 8,  0, 0, 1234, 0, 32'd1234, 1, 0));
    vecs.push_back(mk(2, B + 12, 32'hFFFF_A5A5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 12, 0, 0, 0, 0, 32'h0000_A5A5, 1, 0));
    vecs.push_back(mk(2, B + 16, 32'h6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 16, 0, 0, 0, 0, 32'h2, 1, 0));
    vecs.push_back(mk(2, B + 32'h4C, 32'h1234, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 12, 0, 0, 0, 0, 32'h0000_A5A5, 1, 0));
    vecs.push_back(mk(1, B + 32'h4C, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 20, 0, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(2, B + 28, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, B + 24, 0, 0, 0, 0, 32'h0, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].kind == 0) begin
        key_event(vecs[i].code);
      end else begin
        num_buffer_in = vecs[i].num;
        num_valid_in  = vecs[i].nvalid;
        access(vecs[i].kind == 2, vecs[i].kind == 1, vecs[i].addr, vecs[i].wdata);
        num_valid_in  = 1'b0;
        check($sformatf("vec%0d.rvalid", i), {31'd0, s_rvalid}, {31'd0, vecs[i].exp_rvalid});
        check($sformatf("vec%0d.ack", i), {31'd0, s_ack}, {31'd0, vecs[i].exp_ack});
        if (vecs[i].exp_rvalid)
          check($sformatf("vec%0d.rdata", i), s_rdata, vecs[i].exp_rdata);
      end
    end
    check("led_out", {16'd0, led_out}, 32'h0000_A5A5);
    check("vga_out", {30'd0, vga_result_out}, 32'd2);

    // Full FIFO: key edge coincides with a pop; the push is accepted.
    for (int i = 0; i < 4; i++) key_event(8'h31 + 8'(i));
    @(negedge clk);
    ps2_scancode = 8'h35; ps2_key_pressed = 1'b1; cpu_re = 1'b1; cpu_addr = B + 4;
    @(negedge clk);
    check("fullpp.rdata", cpu_rdata, 32'h31);
    check("fullpp.rvalid", {31'd0, cpu_rvalid}, 32'd1);
    cpu_re = 1'b0; ps2_key_pressed = 1'b0;
    rd_check("fullpp.status", B, 32'h21);
    for (int i = 0; i < 4; i++) rd_check("fullpp.drain", B + 4, 32'h32 + 32'(i));

    // Store and load together: store lands, load dropped.
    access(1'b1, 1'b1, B + 12, 32'h0000_5A5A);
    check("were.rvalid", {31'd0, s_rvalid}, 32'd0);
    check("were.led", {16'd0, led_out}, 32'h5A5A);

    // Empty FIFO: concurrent push and pop returns 0, push lands.
    @(negedge clk);
    ps2_scancode = 8'h44; ps2_key_pressed = 1'b1; cpu_re = 1'b1; cpu_addr = B + 4;
    @(negedge clk);
    check("emptypp.rdata", cpu_rdata, 32'h0);
    check("emptypp.rvalid", {31'd0, cpu_rvalid}, 32'd1);
    cpu_re = 1'b0; ps2_key_pressed = 1'b0;
    rd_check("emptypp.status", B, 32'h09);
    rd_check("emptypp.pop", B + 4, 32'h44);

    // Held key level pushes once.
    @(negedge clk); ps2_scancode = 8'h55; ps2_key_pressed = 1'b1;
    repeat (3) @(negedge clk);
    ps2_key_pressed = 1'b0;
    rd_check("held.status", B, 32'h09);
    rd_check("held.pop", B + 4, 32'h55);

    // Overflow set and CONTROL clear in the same cycle: set wins.
    for (int i = 0; i < 4; i++) key_event(8'h61 + 8'(i));
    @(negedge clk);
    ps2_scancode = 8'h65; ps2_key_pressed = 1'b1; cpu_we = 1'b1; cpu_addr = B + 20; cpu_wdata = 32'h1;
    @(negedge clk);
    cpu_we = 1'b0; ps2_key_pressed = 1'b0;
    rd_check("setwins.status", B, 32'h25);
    for (int i = 0; i < 4; i++) rd_check("setwins.drain", B + 4, 32'h61 + 32'(i));

    // Reset arriving with a NUMBER read cancels rvalid and ack.
    key_event(8'h77);
    access(1'b1, 1'b0, B + 16, 32'h1);
    @(negedge clk);
    rst = 1'b0; cpu_re = 1'b1; cpu_addr = B + 8; num_valid_in = 1'b1; num_buffer_in = 32'd99;
    @(negedge clk);
    check("midrst.rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("midrst.ack", {31'd0, num_read_ack}, 32'd0);
    check("midrst.led", {16'd0, led_out}, 32'd0);
    check("midrst.vga", {30'd0, vga_result_out}, 32'd0);
    rst = 1'b1; cpu_re = 1'b0; num_valid_in = 1'b0;
    rd_check("midrst.status", B, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
